// File: rtl/tm1638_spi_tx_pkg.sv
// Shared types for the TM1638 command serializer: FSM states, word kinds, word layout.
// The RD_* states exist only when TM1638_SPI_KEY_READ_EN is defined.
package tm1638_spi_types;

  typedef enum logic [3:0] {
    S_IDLE,
    S_START,
    S_BIT_LO,
    S_BIT_HI,
    S_STOP,
    S_GAP
`ifdef TM1638_SPI_KEY_READ_EN
    , S_RD_WAIT,
    S_RD_LO,
    S_RD_HI
`endif
  } spi_state_t;

  typedef enum logic [1:0] {
    KIND_BYTE      = 2'b00,
    KIND_ADDR_DATA = 2'b01,
    KIND_READ      = 2'b10,
    KIND_RSVD      = 2'b11
  } word_kind_t;

  localparam int WORD_W   = 18;
  localparam int KIND_MSB = 17;
  localparam int KIND_LSB = 16;
  localparam int HI_MSB   = 15;
  localparam int HI_LSB   = 8;
  localparam int LO_MSB   = 7;
  localparam int LO_LSB   = 0;
  localparam int TMR_W    = 16;

  function automatic word_kind_t word_kind(input logic [WORD_W-1:0] w);
    return word_kind_t'(w[KIND_MSB:KIND_LSB]);
  endfunction

endpackage

// File: rtl/tm1638_spi_tx_fifo.sv
// Synchronous command FIFO with registered count, full/empty flags and a sticky overflow flag.
module tm1638_fifo
  import tm1638_spi_types::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = WORD_W
) (
  input  logic                     i_Clk,
  input  logic                     i_Rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is decoded from the registered count, so a push in the same cycle as a pop is still refused.
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_Clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/tm1638_spi_tx.sv
// TM1638 command serializer: FIFO-buffered, STB-framed, LSB-first 3-wire transfers.
// TM1638_SPI_KEY_READ_EN adds the 4-byte key-scan read (i_DIO, o_Keys, o_Keys_Valid).
//
// state     | meaning
// S_IDLE    | STB high, pop next word when FIFO non-empty
// S_START   | STB low setup before first bit
// S_BIT_LO  | SCLK low, DIO driven with current bit
// S_BIT_HI  | SCLK high, shift at end
// S_STOP    | STB low hold after last bit
// S_GAP     | STB high minimum inter-frame gap
// S_RD_WAIT | DIO released, wait before read clocks
// S_RD_LO   | read SCLK low
// S_RD_HI   | read SCLK high, i_DIO sampled on entry
module tm1638_spi_tx
  import tm1638_spi_types::*;
#(
  parameter int DEPTH   = 16,
  parameter int CLK_DIV = 8,
  parameter int RD_WAIT = 16
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic [WORD_W-1:0] i_Data,
  input  logic              i_Write,
  output logic              o_FIFO_Full,
  output logic              o_Overflow,
  output logic              o_Busy,
  output logic              o_STB,
  output logic              o_SCLK,
  output logic              o_DIO,
`ifdef TM1638_SPI_KEY_READ_EN
  input  logic              i_DIO,
  output logic [31:0]       o_Keys,
  output logic              o_Keys_Valid,
`endif
  output logic              o_DIO_OE
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [TMR_W-1:0] T_HALF = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] T_GAP  = TMR_W'(2 * CLK_DIV - 1);

  logic              fifo_pop;
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_data;
  logic [CW-1:0]     fifo_count;
  word_kind_t        kind;

  spi_state_t        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [15:0]       shift_q, shift_d;
  logic [2:0]        bit_q, bit_d;
  logic              byte2_q, byte2_d;
  logic              dio_q;

`ifdef TM1638_SPI_KEY_READ_EN
  localparam logic [TMR_W-1:0] T_RDW = TMR_W'(RD_WAIT - 1);
  logic              rd_q, rd_d;
  logic [4:0]        rd_cnt_q, rd_cnt_d;
  logic [31:0]       keys_sh_q;
  logic              rd_sample;
  logic              keys_done;
`endif

  tm1638_fifo #(.DEPTH(DEPTH), .WIDTH(WORD_W)) u_fifo (
    .i_Clk    (i_Clk),
    .i_Rst    (i_Rst),
    .push     (i_Write),
    .wr_data  (i_Data),
    .pop      (fifo_pop),
    .rd_data  (fifo_data),
    .full     (o_FIFO_Full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .overflow (o_Overflow)
  );

  assign kind = word_kind(fifo_data);

  always_comb begin
    state_d  = state_q;
    tmr_d    = (tmr_q != '0) ? tmr_q - 1'b1 : tmr_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    byte2_d  = byte2_q;
    fifo_pop = 1'b0;
`ifdef TM1638_SPI_KEY_READ_EN
    rd_d      = rd_q;
    rd_cnt_d  = rd_cnt_q;
    rd_sample = 1'b0;
    keys_done = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (kind != KIND_RSVD) begin
            state_d = S_START;
            tmr_d   = T_HALF;
            bit_d   = '0;
            byte2_d = (kind == KIND_ADDR_DATA);
            // Second byte sits above the first so one right shift walks both in order.
            if (kind == KIND_ADDR_DATA)
              shift_d = {fifo_data[LO_MSB:LO_LSB], fifo_data[HI_MSB:HI_LSB]};
            else
              shift_d = {8'h00, fifo_data[LO_MSB:LO_LSB]};
`ifdef TM1638_SPI_KEY_READ_EN
            rd_d = (kind == KIND_READ);
`endif
          end
        end
      end
      S_START: begin
        if (tmr_q == '0) begin
          state_d = S_BIT_LO;
          tmr_d   = T_HALF;
        end
      end
      S_BIT_LO: begin
        if (tmr_q == '0) begin
          state_d = S_BIT_HI;
          tmr_d   = T_HALF;
        end
      end
      S_BIT_HI: begin
        if (tmr_q == '0) begin
          tmr_d   = T_HALF;
          shift_d = {1'b0, shift_q[15:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q != 3'd7) begin
            state_d = S_BIT_LO;
          end else if (byte2_q) begin
            byte2_d = 1'b0;
            state_d = S_BIT_LO;
          end
`ifdef TM1638_SPI_KEY_READ_EN
          else if (rd_q) begin
            state_d = S_RD_WAIT;
            tmr_d   = T_RDW;
          end
`endif
          else begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tmr_q == '0) begin
          state_d = S_GAP;
          tmr_d   = T_GAP;
        end
      end
      S_GAP: begin
        if (tmr_q == '0) state_d = S_IDLE;
      end
`ifdef TM1638_SPI_KEY_READ_EN
      S_RD_WAIT: begin
        if (tmr_q == '0) begin
          state_d  = S_RD_LO;
          tmr_d    = T_HALF;
          rd_cnt_d = '0;
        end
      end
      S_RD_LO: begin
        if (tmr_q == '0) begin
          state_d   = S_RD_HI;
          tmr_d     = T_HALF;
          rd_sample = 1'b1;
        end
      end
      S_RD_HI: begin
        if (tmr_q == '0) begin
          tmr_d    = T_HALF;
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (rd_cnt_q == 5'd31) begin
            state_d   = S_STOP;
            keys_done = 1'b1;
            rd_d      = 1'b0;
          end else begin
            state_d = S_RD_LO;
          end
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      byte2_q <= 1'b0;
      dio_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      byte2_q <= byte2_d;
      // DIO only moves together with the SCLK falling edge, or once STB is high again.
      if (state_d == S_BIT_LO && state_q != S_BIT_LO)
        dio_q <= shift_d[0];
      else if (state_d == S_GAP)
        dio_q <= 1'b1;
    end
  end

`ifdef TM1638_SPI_KEY_READ_EN
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      rd_q         <= 1'b0;
      rd_cnt_q     <= '0;
      keys_sh_q    <= '0;
      o_Keys       <= '0;
      o_Keys_Valid <= 1'b0;
    end else begin
      rd_q         <= rd_d;
      rd_cnt_q     <= rd_cnt_d;
      o_Keys_Valid <= keys_done;
      if (rd_sample) keys_sh_q <= {i_DIO, keys_sh_q[31:1]};
      if (keys_done) o_Keys <= keys_sh_q;
    end
  end

  assign o_SCLK   = !(state_q == S_BIT_LO || state_q == S_RD_LO);
  assign o_DIO_OE = !(state_q == S_RD_WAIT || state_q == S_RD_LO || state_q == S_RD_HI);
`else
  assign o_SCLK   = (state_q != S_BIT_LO);
  assign o_DIO_OE = 1'b1;
`endif

  assign o_STB  = (state_q == S_IDLE) || (state_q == S_GAP);
  assign o_DIO  = dio_q;
  assign o_Busy = (state_q != S_IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_tm1638_spi_tx.sv
// Self-checking bench for tm1638_spi_tx: frame scoreboard, vector table, FIFO full/overflow and reset abort.
module tb_tm1638_spi_tx;

  localparam int DEPTH = 16;
  localparam int CD    = 2;
  localparam int RW    = 16;

  logic        clk = 1'b0;
  logic        i_Rst = 1'b1;
  logic [17:0] i_Data = '0;
  logic        i_Write = 1'b0;
  logic        o_FIFO_Full, o_Overflow, o_Busy, o_STB, o_SCLK, o_DIO, o_DIO_OE;
`ifdef TM1638_SPI_KEY_READ_EN
  logic        i_DIO = 1'b0;
  logic [31:0] o_Keys;
  logic        o_Keys_Valid;
  logic [31:0] key_pat = 32'h8000_0001;
`endif

  always #5 clk = ~clk;

  tm1638_spi_tx #(.DEPTH(DEPTH), .CLK_DIV(CD), .RD_WAIT(RW)) dut (
    .i_Clk        (clk),
    .i_Rst        (i_Rst),
    .i_Data       (i_Data),
    .i_Write      (i_Write),
    .o_FIFO_Full  (o_FIFO_Full),
    .o_Overflow   (o_Overflow),
    .o_Busy       (o_Busy),
    .o_STB        (o_STB),
    .o_SCLK       (o_SCLK),
    .o_DIO        (o_DIO),
`ifdef TM1638_SPI_KEY_READ_EN
    .i_DIO        (i_DIO),
    .o_Keys       (o_Keys),
    .o_Keys_Valid (o_Keys_Valid),
`endif
    .o_DIO_OE     (o_DIO_OE)
  );

  typedef struct {
    logic [17:0] word;
    int          nbits;
    logic [15:0] bits;
    int          len;
    bit          rd;
  } vec_t;

  vec_t exp_q[$];
  vec_t vecs[6];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor: captures DIO on SCLK rising edges while STB is low.
  bit          prev_stb = 1'b1, prev_sclk = 1'b1, prev_dio = 1'b1, abort = 1'b0, unstable = 1'b0;
  int          stb_len = 0, nbits_cur = 0, rd_edges = 0, oe_low = 0;
  int          stb_falls = 0, frames_done = 0, kv_cnt = 0;
  logic [15:0] bits_cur = '0;

  always @(negedge clk) begin : mon
    vec_t e;
    if (i_Rst) abort = 1'b1;
    if (!o_STB) begin
      if (prev_stb) begin
        stb_len = 0; nbits_cur = 0; bits_cur = '0; rd_edges = 0; oe_low = 0; unstable = 1'b0;
        stb_falls++;
      end
      stb_len++;
      if (o_SCLK && !prev_sclk) begin
        if (o_DIO_OE) begin
          if (nbits_cur < 16) bits_cur[nbits_cur] = o_DIO;
          nbits_cur++;
          if (o_DIO != prev_dio) unstable = 1'b1;
        end else begin
          rd_edges++;
        end
      end
      if (!o_DIO_OE) oe_low++;
    end else if (!prev_stb) begin
      if (abort) begin
        abort = 1'b0;
      end else if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_frame: got frame of %0d bits, expected none", nbits_cur);
      end else begin
        e = exp_q.pop_front();
        check("frame_nbits", nbits_cur, e.nbits);
        check("frame_bits", bits_cur, e.bits);
        check("stb_low_len", stb_len, e.len);
        check("dio_stable", unstable, 0);
        check("read_edges", rd_edges, e.rd ? 32 : 0);
        check("oe_released", oe_low != 0, e.rd);
        frames_done++;
      end
    end else if (!i_Rst) begin
      abort = 1'b0;
    end
`ifdef TM1638_SPI_KEY_READ_EN
    if (o_Keys_Valid) kv_cnt++;
    i_DIO = (rd_edges < 32) ? key_pat[rd_edges] : 1'b0;
`endif
    prev_stb  = o_STB;
    prev_sclk = o_SCLK;
    prev_dio  = o_DIO;
  end

  task automatic push_word(input logic [17:0] w);
    @(posedge clk); #1;
    i_Data  = w;
    i_Write = 1'b1;
    @(posedge clk); #1;
    i_Write = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((o_Busy || !o_STB) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle"}, {o_Busy, !o_STB}, 2'b00);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, f0, s0;
    vecs[0] = '{18'h0008F, 8,  16'h008F, 36, 1'b0};
    vecs[1] = '{18'h1C35A, 16, 16'h5AC3, 68, 1'b0};
    vecs[2] = '{18'h00000, 8,  16'h0000, 36, 1'b0};
    vecs[3] = '{18'h1FF00, 16, 16'h00FF, 68, 1'b0};
    vecs[4] = '{18'h3FFFF, 0,  16'h0000, 0,  1'b0};
`ifdef TM1638_SPI_KEY_READ_EN
    vecs[5] = '{18'h20042, 8,  16'h0042, 180, 1'b1};
`else
    vecs[5] = '{18'h20042, 8,  16'h0042, 36,  1'b0};
`endif

    repeat (3) @(posedge clk);
    #1 i_Rst = 1'b0;
    @(negedge clk);
    check("reset_stb", o_STB, 1);
    check("reset_sclk", o_SCLK, 1);
    check("reset_dio", o_DIO, 1);
    check("reset_oe", o_DIO_OE, 1);
    check("reset_full", o_FIFO_Full, 0);
    check("reset_overflow", o_Overflow, 0);
    check("reset_busy", o_Busy, 0);
`ifdef TM1638_SPI_KEY_READ_EN
    check("reset_keys", o_Keys, 0);
    check("reset_keys_valid", o_Keys_Valid, 0);
`endif

    // STB falls two cycles after the push: write, then pop.
    exp_q.push_back('{18'h000A5, 8, 16'h00A5, 36, 1'b0});
    push_word(18'h000A5);
    @(negedge clk);
    check("latency_pre", o_STB, 1);
    @(negedge clk);
    check("latency_fall", o_STB, 0);
    wait_idle("latency", 500);

    for (int i = 0; i < 6; i++) begin
      f0 = frames_done;
      s0 = stb_falls;
      if (vecs[i].nbits != 0) exp_q.push_back(vecs[i]);
      push_word(vecs[i].word);
      wait_idle($sformatf("vec%0d", i), 1000);
      check($sformatf("vec%0d_frames", i), frames_done - f0, (vecs[i].nbits != 0) ? 1 : 0);
      check($sformatf("vec%0d_stb_falls", i), stb_falls - s0, (vecs[i].nbits != 0) ? 1 : 0);
      check($sformatf("vec%0d_queue", i), exp_q.size(), 0);
    end

`ifdef TM1638_SPI_KEY_READ_EN
    check("keys_value", o_Keys, 32'h8000_0001);
    check("keys_valid_pulses", kv_cnt, 1);
`endif

    // Burst of 20 pushes while a frame runs: 16 fit, 4 are dropped.
    exp_q.push_back('{18'h00011, 8, 16'h0011, 36, 1'b0});
    push_word(18'h00011);
    n = 0;
    while (o_STB && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("burst_frame_started", o_STB, 0);
    for (int i = 0; i < 20; i++) begin
      logic [7:0] b;
      b = 8'h30 + 8'(i);
      @(posedge clk); #1;
      i_Data  = {10'h000, b};
      i_Write = 1'b1;
      if (i < 16) exp_q.push_back('{{10'h000, b}, 8, {8'h00, b}, 36, 1'b0});
      @(negedge clk);
      if (i == 15) check("full_before_depth", o_FIFO_Full, 0);
      if (i == 16) begin
        check("full_at_depth", o_FIFO_Full, 1);
        check("overflow_before_drop", o_Overflow, 0);
      end
      if (i == 17) check("overflow_set", o_Overflow, 1);
    end
    @(posedge clk); #1;
    i_Write = 1'b0;
    wait_idle("burst", 3000);
    check("burst_queue", exp_q.size(), 0);
    check("overflow_sticky", o_Overflow, 1);

    // Reset during the second byte of an address+data frame, with another word queued.
    exp_q.push_back('{18'h1C35A, 16, 16'h5AC3, 68, 1'b0});
    push_word(18'h1C35A);
    exp_q.push_back('{18'h00077, 8, 16'h0077, 36, 1'b0});
    push_word(18'h00077);
    n = 0;
    @(negedge clk);
    while (!(nbits_cur == 8 && !o_SCLK && !o_STB) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reached_second_byte", {o_STB, o_SCLK}, 2'b00);
    @(posedge clk); #1;
    i_Rst = 1'b1;
    @(posedge clk); #1;
    i_Rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("abort_stb", o_STB, 1);
    check("abort_sclk", o_SCLK, 1);
    check("abort_dio", o_DIO, 1);
    check("abort_busy", o_Busy, 0);
    check("abort_full", o_FIFO_Full, 0);
    check("abort_overflow", o_Overflow, 0);
    s0 = stb_falls;
    repeat (200) @(negedge clk);
    check("no_frame_after_reset", stb_falls - s0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
